load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the address generator: takes the computed effective address for LOAD/STORE opcodes plus rs2 store data.
- Checks alignment and builds word-aligned byte-masked requests. Runs a req/gnt/rvalid handshake with the data memory.
- Returns sign/zero-extended load data to writeback. Stalls the core while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles waiting for mem_gnt or mem_rvalid before raising access_fault (>=2).
- XLEN, 32, data/address width (only 32 supported).

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-low reset
- valid  input  1  access request from execute stage, sampled only in IDLE
- opcode  input  7  instruction opcode; only `LOAD / `STORE start an access
- funct3  input  3  access size/sign (LB,LH,LW,LBU,LHU / SB,SH,SW)
- address  input  32  effective address from address generator
- store_data  input  32  rs2 value
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  32  {address[31:2],2'b00}
- mem_wdata  output  32  store data replicated into byte lanes
- mem_mask  output  4  byte enables
- mem_gnt  input  1  request accepted
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read word
- busy  output  1  stall to core
- load_valid  output  1  one-cycle pulse, load_data valid
- load_data  output  32  extended load result
- store_done  output  1  one-cycle pulse on store grant
- misaligned  output  1  one-cycle pulse, alignment exception
- access_fault  output  1  one-cycle pulse, illegal funct3 or timeout
- fault_address  output  32  effective address of faulting access

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, including fault_address. The timeout counter clears.
- States: IDLE, REQ, WAIT_RSP.
- IDLE: when valid=1 and opcode is `LOAD or `STORE, latch address, funct3, store_data and opcode.
  - Illegal funct3 (load 011/110/111, store >=011): access_fault pulses next cycle; stay IDLE.
  - Misaligned (H: addr[0]≠0; W: addr[1:0]≠0): misaligned pulses next cycle; stay IDLE; no mem_req.
  - Otherwise go to REQ.
  - fault_address updates with every fault pulse.
  - Any other opcode, or valid=0: no action.
- busy = (state≠IDLE) OR (valid AND LOAD/STORE opcode in IDLE). This is combinational so the core stalls in the accept cycle.
- Mask generation:
  - B: 4'b0001<<addr[1:0]
  - H: 4'b0011<<addr[1:0]
  - W: 4'b1111
  - wdata: B = {4{sd[7:0]}}, H = {2{sd[15:0]}}, W = sd.
- REQ: mem_req=1. mem_we, mem_addr, mem_mask and mem_wdata are registered and held stable until mem_gnt=1.
  - On gnt, store: store_done pulses, go to IDLE.
  - On gnt, load: go to WAIT_RSP.
  - Load with gnt and rvalid in the same cycle: complete directly and go to IDLE.
- WAIT_RSP: mem_req=0. On mem_rvalid, extract the lane selected by latched addr[1:0] and extend (LB/LH sign, LBU/LHU zero). load_data is registered, load_valid pulses 1 cycle, go to IDLE.
- load_data holds its last value until the next load completes.
- Timeout: the counter resets on entry to REQ and on gnt. If it reaches TIMEOUT_CYCLES in REQ or WAIT_RSP, access_fault pulses, go to IDLE, and mem_req drops.
- mem_rvalid or mem_gnt arriving in IDLE is ignored (stale response after timeout/reset).
- Reset mid-access: the request is abandoned immediately and mem_req drops asynchronously.
- At most one access outstanding; no pipelining.

Decomposition:
- Add funct3 access-size constants (LB, LH, LW, LBU, LHU, SB, SH, SW) to Defines.v next to the existing `LOAD/`STORE opcodes.
- State encodings are localparams in the module.
- One combinational sub-module, load_data_aligner (rdata, byte offset, funct3 -> extended 32-bit value), shared with future MMIO paths.

Test Plan:
- SW to 0x0000_1004, sd=0xDEADBEEF, gnt after 2 cycles -> mem_addr=0x1004, mask=1111, wdata=0xDEADBEEF held for 3 cycles, store_done one pulse, busy low next cycle.
- LB at 0x103, rdata=0x80FF_0000, gnt+rvalid same cycle -> mask=1000, load_data=0xFFFF_FF80, load_valid 1 cycle; repeat as LBU -> 0x0000_0080.
- LH at 0x2001 -> misaligned pulse, fault_address=0x2001, mem_req never asserted; LW at 0x2002 -> same.
- SH at 0x06, sd=0x1234ABCD -> mask=1100, wdata=0xABCDABCD; funct3=011 load -> access_fault, no request.
- LW with gnt but rvalid never asserted (TIMEOUT_CYCLES=16) -> access_fault exactly 16 cycles after gnt; a later stray rvalid is ignored (no load_valid).
- reset asserted while in REQ -> mem_req low immediately, all outputs 0; a new LW after release completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared constants and request-building helpers for the load/store unit.
package load_store_unit_pkg;

  // Opcodes that start a memory access
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Access size / sign encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Size field (funct3[1:0]) values
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // True when funct3 names a supported access for the given direction
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one
  function automatic logic f3_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte enables for the selected lane(s) of the aligned word
  function automatic logic [3:0] f3_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << off;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate store data into every lane so the mask alone selects the bytes
  function automatic logic [31:0] f3_wdata(input logic [1:0] size, input logic [31:0] sd);
    logic [31:0] w;
    w = 32'h0000_0000;
    case (size)
      SZ_B:    w = {4{sd[7:0]}};
      SZ_H:    w = {2{sd[15:0]}};
      SZ_W:    w = sd;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_store_unit_aligner.sv
// Picks the addressed lane out of a read word and sign/zero extends it.
// Purely combinational so other read paths can reuse it.
module load_data_aligner
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted_s;

  // Shift the addressed byte to lane 0, then extend per access type
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    data      = 32'h0000_0000;
    case (funct3)
      F3_LB:   data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_LH:   data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_LW:   data = shifted_s;
      F3_LBU:  data = {24'h00_0000, shifted_s[7:0]};
      F3_LHU:  data = {16'h0000, shifted_s[15:0]};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: validates the access, issues one word-aligned
// byte-masked request over req/gnt/rvalid and returns extended load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_mask,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic            store_done,
  output logic            misaligned,
  output logic            access_fault,
  output logic [XLEN-1:0] fault_address
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_t;

  // Counter runs 0..TIMEOUT_CYCLES-1; hitting the last value with no
  // handshake progress means TIMEOUT_CYCLES cycles have elapsed.
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  state_t            state_r;
  logic [1:0]        offset_r;
  logic [2:0]        funct3_r;
  logic              is_store_r;
  logic [TMO_W-1:0]  tmo_cnt_r;

  logic              is_store_s;
  logic              is_ls_s;
  logic              illegal_s;
  logic              misal_s;
  logic              tmo_hit_s;
  logic [XLEN-1:0]   aligned_s;

  // Decode the incoming request and drive the combinational stall
  always_comb begin
    is_store_s = (opcode == OPC_STORE);
    is_ls_s    = (opcode == OPC_LOAD) || is_store_s;
    illegal_s  = !f3_legal(is_store_s, funct3);
    misal_s    = f3_misaligned(funct3[1:0], address[1:0]);
    tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
    busy       = (state_r != ST_IDLE) || (valid && is_ls_s);
  end

  load_data_aligner u_aligner (
    .rdata  (mem_rdata),
    .offset (offset_r),
    .funct3 (funct3_r),
    .data   (aligned_s)
  );

  // Access FSM with registered memory-side and writeback-side outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      offset_r      <= 2'b00;
      funct3_r      <= 3'b000;
      is_store_r    <= 1'b0;
      tmo_cnt_r     <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_mask      <= 4'b0000;
      load_valid    <= 1'b0;
      load_data     <= '0;
      store_done    <= 1'b0;
      misaligned    <= 1'b0;
      access_fault  <= 1'b0;
      fault_address <= '0;
    end else begin
      load_valid   <= 1'b0;
      store_done   <= 1'b0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid && is_ls_s) begin
            offset_r   <= address[1:0];
            funct3_r   <= funct3;
            is_store_r <= is_store_s;
            if (illegal_s) begin
              access_fault  <= 1'b1;
              fault_address <= address;
            end else if (misal_s) begin
              misaligned    <= 1'b1;
              fault_address <= address;
            end else begin
              state_r   <= ST_REQ;
              tmo_cnt_r <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store_s;
              mem_addr  <= {address[XLEN-1:2], 2'b00};
              mem_mask  <= f3_mask(funct3[1:0], address[1:0]);
              mem_wdata <= f3_wdata(funct3[1:0], store_data);
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            tmo_cnt_r <= '0;
            if (is_store_r) begin
              store_done <= 1'b1;
              state_r    <= ST_IDLE;
            end else if (mem_rvalid) begin
              load_data  <= aligned_s;
              load_valid <= 1'b1;
              state_r    <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT_RSP;
            end
          end else if (tmo_hit_s) begin
            mem_req       <= 1'b0;
            access_fault  <= 1'b1;
            fault_address <= {mem_addr[XLEN-1:2], offset_r};
            state_r       <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_WAIT_RSP: begin
          if (mem_rvalid) begin
            load_data  <= aligned_s;
            load_valid <= 1'b1;
            state_r    <= ST_IDLE;
          end else if (tmo_hit_s) begin
            access_fault  <= 1'b1;
            fault_address <= {mem_addr[XLEN-1:2], offset_r};
            state_r       <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
